// File: rtl/fft8_input_loader_if.sv
// Handshake bundle for the FFT8 input loader: serial FP16 sample stream in,
// parallel bit-reversed frame out to the first butterfly stage.
interface fft8_input_loader_if #(
    parameter int DATA_W = 16,
    parameter int N      = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_re;
    logic [DATA_W-1:0]   in_im;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W*N-1:0] out_re;
    logic [DATA_W*N-1:0] out_im;
    logic                out_special;
    logic                frame_err;

    modport master (
        output in_valid, in_re, in_im, in_last, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_special, frame_err
    );

    modport slave (
        input  in_valid, in_re, in_im, in_last, out_ready,
        output in_ready, out_valid, out_re, out_im, out_special, frame_err
    );
endinterface

// File: rtl/fft8_input_loader.sv
// Collects 8 serial complex FP16 samples into bit-reversed slots and hands the
// whole frame to the first radix-2 butterfly stage; flags Inf/NaN and framing errors.
module fft8_input_loader #(
    parameter int DATA_W = 16,
    parameter int N      = 8,
    parameter int ADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    fft8_input_loader_if.slave bus
);
    localparam int EXP_MSB = 14;
    localparam int EXP_LSB = 10;

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] slot_re [N];
    logic [DATA_W-1:0] slot_im [N];
    logic              frame_special;
    logic              frame_special_nxt;
    logic              out_special_r;
    logic              frame_err_r;
    logic              in_ready_c;
    logic              accept;
    logic              last_slot;
    logic              abort;

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
        return r;
    endfunction

    // All-ones exponent covers both Inf and NaN encodings.
    function automatic logic is_special(input logic [DATA_W-1:0] w);
        return &w[EXP_MSB:EXP_LSB];
    endfunction

    assign in_ready_c = (state == LOAD) && !rst;
    assign accept     = bus.in_valid && in_ready_c;
    assign last_slot  = (cnt == ADDR_W'(N-1));
    assign abort      = bus.in_last && !last_slot;

    // The first sample of a frame starts a fresh flag before its own check.
    assign frame_special_nxt = ((cnt != '0) && frame_special)
                             | is_special(bus.in_re) | is_special(bus.in_im);

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == LOAD) begin
            if (accept && last_slot) state_nxt = FULL;
        end else begin
            if (bus.out_ready) state_nxt = LOAD;
        end
    end

    always_comb begin
        bus.in_ready    = in_ready_c;
        bus.out_valid   = (state == FULL);
        bus.out_special = out_special_r;
        bus.frame_err   = frame_err_r;
        bus.out_re      = '0;
        bus.out_im      = '0;
        for (int i = 0; i < N; i++) begin
            bus.out_re[DATA_W*i +: DATA_W] = slot_re[i];
            bus.out_im[DATA_W*i +: DATA_W] = slot_im[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            frame_special <= 1'b0;
            out_special_r <= 1'b0;
            frame_err_r   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                slot_re[i] <= '0;
                slot_im[i] <= '0;
            end
        end else begin
            frame_err_r <= accept && (bus.in_last != last_slot);
            if (accept) begin
                slot_re[bitrev(cnt)] <= bus.in_re;
                slot_im[bitrev(cnt)] <= bus.in_im;
                if (abort) begin
                    cnt           <= '0;
                    frame_special <= 1'b0;
                end else begin
                    cnt           <= cnt + 1'b1;
                    frame_special <= frame_special_nxt;
                end
                if (last_slot) out_special_r <= frame_special_nxt;
            end
        end
    end
endmodule
